// File: rtl/mio_bus_ctrl.sv
// ============================================================================
// mio_bus_ctrl : CPU memory/IO bus controller (data RAM, GPIO, timer/counter)
// Rev 1.0
// ============================================================================
`default_nettype none

module mio_bus_ctrl #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_from_cpu,
  output logic [31:0]       Data_to_cpu,
  output logic              MIO_ready,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              INT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [29:0] c_gpio_wa = 30'h3800_0000;
  localparam logic [29:0] c_cnt_wa  = 30'h3C00_0000;
  localparam logic [29:0] c_cmp_wa  = 30'h3C00_0001;
  localparam logic [29:0] c_ctrl_wa = 30'h3C00_0002;
  localparam logic [3:0]  c_lat_last = 4'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        flag_q, flag_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic        w_ram_hit, w_sel_gpio, w_sel_cnt, w_sel_cmp, w_sel_ctrl;
  logic        w_last, w_pwr, w_match;
  logic [31:0] w_periph_rdata;
  logic        w_unused;

  // Byte-lane bits of the address carry no information on a word bus
  assign w_unused = &{1'b0, Addr_in[1:0]};

  assign w_ram_hit  = (addr_q[29:RAM_AW] == '0);
  assign w_sel_gpio = (addr_q == c_gpio_wa);
  assign w_sel_cnt  = (addr_q == c_cnt_wa);
  assign w_sel_cmp  = (addr_q == c_cmp_wa);
  assign w_sel_ctrl = (addr_q == c_ctrl_wa);

  assign w_last  = wr_q || !w_ram_hit || (lat_q == c_lat_last);
  assign w_pwr   = (state_q == ACCESS) && wr_q;
  assign w_match = en_q && (cnt_q == cmp_q);

  always_comb begin
    w_periph_rdata = 32'h0;
    if (w_sel_gpio)      w_periph_rdata = {16'h0, sw_sync_q};
    else if (w_sel_cnt)  w_periph_rdata = cnt_q;
    else if (w_sel_cmp)  w_periph_rdata = cmp_q;
    else if (w_sel_ctrl) w_periph_rdata = {30'h0, flag_q, en_q};
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    MIO_ready = 1'b0;
    case (state_q)
      IDLE: begin
        lat_d = 4'd0;
        if (CPU_MIO) state_d = ACCESS;
      end
      ACCESS: begin
        ram_we = wr_q && w_ram_hit && (lat_q == 4'd0);
        if (w_last) begin
          state_d = DONE;
          if (!wr_q) rdata_d = w_ram_hit ? ram_dout : w_periph_rdata;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      DONE: begin
        MIO_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus writes win over counting; a match on the pre-write value still flags
  always_comb begin
    led_d  = led_q;
    cmp_d  = cmp_q;
    en_d   = en_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (en_q) cnt_d = w_match ? 32'h0 : cnt_q + 32'd1;
    if (w_pwr && w_sel_gpio) led_d = wdata_q[15:0];
    if (w_pwr && w_sel_cnt)  cnt_d = wdata_q;
    if (w_pwr && w_sel_cmp)  cmp_d = wdata_q;
    if (w_pwr && w_sel_ctrl) begin
      en_d = wdata_q[0];
      if (wdata_q[1]) flag_d = 1'b0;
    end
    if (w_match) flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= 4'd0;
      addr_q    <= 30'h0;
      wdata_q   <= 32'h0;
      wr_q      <= 1'b0;
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      cnt_q     <= 32'h0;
      cmp_q     <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      flag_q    <= 1'b0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      flag_q    <= flag_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      if (state_q == IDLE && CPU_MIO) begin
        addr_q  <= Addr_in[31:2];
        wdata_q <= Data_from_cpu;
        wr_q    <= mem_w;
      end
    end
  end

  assign Data_to_cpu = rdata_q;
  assign ram_addr    = addr_q[RAM_AW-1:0];
  assign ram_din     = wdata_q;
  assign led_out     = led_q;
  assign INT         = flag_q;

endmodule

`default_nettype wire

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the single-cycle CPU core.
- Consumes the core's request (CPU_MIO, mem_w, address, store data) and decodes the address to one of three targets: data RAM, GPIO, or a timer/counter.
- Returns read data with a MIO_ready handshake and drives the core's INT input from a timer match flag.

Parameters:
RAM_AW, 10, RAM word-address width; RAM spans 4*2^RAM_AW bytes from 0x0000_0000.
RAM_LAT, 1, RAM read latency in cycles, legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
CPU_MIO  in  1  request strobe from CPU; sampled only in IDLE.
mem_w  in  1  1 = write, 0 = read; sampled with CPU_MIO.
Addr_in  in  32  byte address from CPU; bits [1:0] ignored.
Data_from_cpu  in  32  store data.
Data_to_cpu  out  32  read data; valid while MIO_ready = 1, held afterwards until the next read completes.
MIO_ready  out  1  one-cycle completion pulse.
ram_we  out  1  RAM write enable.
ram_addr  out  RAM_AW  RAM word address.
ram_din  out  32  RAM write data.
ram_dout  in  32  RAM read data, valid RAM_LAT cycles after the address is presented.
sw_in  in  16  switch inputs, asynchronous.
led_out  out  16  LED register.
INT  out  1  timer interrupt flag to CPU.

Behaviour:
- Reset: all outputs and registers go to 0, except compare, which resets to 0xFFFF_FFFF. FSM resets to IDLE. Reset mid-transaction aborts it; no MIO_ready is produced.
- Address decode (on the latched address):
  - RAM: Addr[31:RAM_AW+2] == 0.
  - 0xE000_0000: GPIO. Write sets led_out = data[15:0]. Read returns {16'h0, sw_sync}.
  - 0xF000_0000: counter value (R/W).
  - 0xF000_0004: compare (R/W).
  - 0xF000_0008: ctrl. Bit0 = enable (R/W). Bit1 = irq flag; reads the flag, writing 1 clears it.
  - Anything else is unmapped: read returns 0, write is ignored, and the transaction still completes normally.
- sw_in passes through a 2-flop synchroniser; sw_sync is the second flop.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if CPU_MIO = 1, latch Addr_in, Data_from_cpu and mem_w, then go to ACCESS. Otherwise stay.
- ACCESS:
  - ram_addr and ram_din come from the latches.
  - ram_we = latched mem_w AND RAM hit. It is high for exactly the first ACCESS cycle only.
  - A peripheral or any write takes 1 ACCESS cycle.
  - A RAM read takes RAM_LAT ACCESS cycles. On the last one, ram_dout is captured into Data_to_cpu.
  - Peripheral read data is captured in the single ACCESS cycle.
  - Peripheral register writes take effect at the end of the ACCESS cycle.
  - Next state is DONE.
- DONE: MIO_ready = 1 for this one cycle, then go to IDLE.
- Latency: request accepted at edge 0.
  - Peripheral access or any write: MIO_ready high in cycle 2.
  - RAM read: MIO_ready high in cycle RAM_LAT + 1.
- CPU_MIO in ACCESS or DONE is ignored. A request held high is re-accepted on the first IDLE cycle, so back-to-back transfers are one every 3+ cycles.
- Writes do not change Data_to_cpu.
- Counter (32-bit):
  - Increments by 1 each cycle while enable = 1.
  - When enable = 1 and counter == compare, the next value is 0 and the flag is set.
  - Wraps 0xFFFF_FFFF -> 0 naturally if compare is never matched.
- INT = flag (registered).
- Simultaneous events:
  - A CPU counter write overrides increment or wrap in the same cycle. The flag is still set if the pre-write value matched.
  - A flag clear in the same cycle as a flag set: set wins.
  - A compare write in the same cycle as a match: the match uses the old compare.

Test Plan:
- Reset asserted mid-ACCESS of a RAM read -> next cycle: FSM IDLE, MIO_ready = 0, led_out = 0, compare = 0xFFFF_FFFF, INT = 0.
- RAM_LAT = 2: write 0xDEADBEEF to 0x0000_0010 -> ram_we = 1 for one cycle with ram_addr = 4, MIO_ready in cycle 2. Then read 0x10 -> Data_to_cpu = 0xDEADBEEF with MIO_ready in cycle 3.
- Write 0x0001_A5A5 to 0xE000_0000 -> led_out = 0xA5A5. sw_in = 0x1234 held for 3 cycles, then read 0xE000_0000 -> 0x0000_1234.
- compare = 5, ctrl = 1 -> counter counts 0..5, then 0. INT rises the cycle after the counter reads 5. Write 2 to 0xF000_0008 -> INT = 0. A clear coinciding with the next match -> INT stays 1.
- Read 0x8000_0000 (unmapped) -> Data_to_cpu = 0, MIO_ready in cycle 2. CPU_MIO held high continuously -> exactly one MIO_ready per 3 cycles.
- Counter write of 100 in the same cycle as a match at compare = 7 -> counter = 100, flag set.
